// File: rtl/result_accumulator_if.sv
// Handshake/data bundle between the upstream result stream, the accumulator and its consumer.
// master = stimulus/consumer side, slave = result_accumulator.
interface result_accumulator_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SUM_W  = 12,
  parameter int unsigned CNT_W  = 3
);
  logic              start_i;
  logic              in_valid_i;
  logic [DATA_W-1:0] data_i;
  logic              result_ready_i;
  logic              busy_o;
  logic              result_valid_o;
  logic [SUM_W-1:0]  sum_o;
  logic [DATA_W-1:0] max_o;
  logic [CNT_W-1:0]  count_o;
  logic              overflow_o;

  modport master (
    output start_i, in_valid_i, data_i, result_ready_i,
    input  busy_o, result_valid_o, sum_o, max_o, count_o, overflow_o
  );

  modport slave (
    input  start_i, in_valid_i, data_i, result_ready_i,
    output busy_o, result_valid_o, sum_o, max_o, count_o, overflow_o
  );
endinterface

// File: rtl/result_accumulator.sv
// Batches N_SAMPLES qualified results into sum/max/count with a valid/ready result handshake.
// Define SATURATE_EN to clamp the sum at all-ones on overflow instead of wrapping.
module result_accumulator #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SUM_W     = 12,
  parameter int unsigned N_SAMPLES = 4
) (
  input logic                 clk_i,
  input logic                 reset_n,
  result_accumulator_if.slave bus
);
  localparam int unsigned CNT_W   = $clog2(N_SAMPLES + 1);
  localparam int unsigned SumExtW = SUM_W + 1;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e            state_q, state_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [SUM_W:0]    sum_ext;

  // Extra MSB captures the carry out of the SUM_W-bit add.
  assign sum_ext = {1'b0, sum_q} + SumExtW'(bus.data_i);

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    max_d      = max_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          state_d    = StAccum;
          sum_d      = '0;
          max_d      = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      StAccum: begin
        if (bus.in_valid_i) begin
          overflow_d = overflow_q | sum_ext[SUM_W];
`ifdef SATURATE_EN
          sum_d = (overflow_q || sum_ext[SUM_W]) ? '1 : sum_ext[SUM_W-1:0];
`else
          sum_d = sum_ext[SUM_W-1:0];
`endif
          if (bus.data_i > max_q) max_d = bus.data_i;
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(N_SAMPLES - 1)) state_d = StDone;
        end
      end
      StDone: begin
        if (bus.result_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      sum_q      <= '0;
      max_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy_o         = (state_q == StAccum);
  assign bus.result_valid_o = (state_q == StDone);
  assign bus.sum_o          = sum_q;
  assign bus.max_o          = max_q;
  assign bus.count_o        = count_q;
  assign bus.overflow_o     = overflow_q;
endmodule

// File: tb/tb_result_accumulator.sv
// Scoreboarded bench: stimulus pushes expected batch results, per-DUT monitors compare while valid.
// dut_a uses N_SAMPLES=4, dut_b uses N_SAMPLES=20 for the overflow case.
module tb_result_accumulator;
  typedef struct {
    int sum;
    int max;
    int count;
    int ovf;
  } exp_t;

  logic clk_i;
  logic reset_n;
  int   checks;
  int   passed;
  exp_t exp_a[$];
  exp_t exp_b[$];

  result_accumulator_if #(.DATA_W(8), .SUM_W(12), .CNT_W(3)) a_if ();
  result_accumulator_if #(.DATA_W(8), .SUM_W(12), .CNT_W(5)) b_if ();

  result_accumulator #(.DATA_W(8), .SUM_W(12), .N_SAMPLES(4)) dut_a (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .bus     (a_if.slave)
  );

  result_accumulator #(.DATA_W(8), .SUM_W(12), .N_SAMPLES(20)) dut_b (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .bus     (b_if.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_a();
    a_if.start_i = 1'b1;
    tick();
    a_if.start_i = 1'b0;
  endtask

  task automatic send_a(input int v);
    a_if.in_valid_i = 1'b1;
    a_if.data_i     = 8'(v);
    tick();
    a_if.in_valid_i = 1'b0;
  endtask

  task automatic release_a();
    a_if.result_ready_i = 1'b1;
    tick();
    a_if.result_ready_i = 1'b0;
  endtask

  // Monitors: compare every cycle the result is presented; pop on the accepting handshake.
  always @(negedge clk_i) begin
    if (reset_n && a_if.result_valid_o) begin
      if (exp_a.size() == 0) begin
        checks++;
        $display("FAIL a_unexpected: got result_valid=1 expected no pending batch");
      end else begin
        check("a_sum", 32'(a_if.sum_o), exp_a[0].sum);
        check("a_max", 32'(a_if.max_o), exp_a[0].max);
        check("a_count", 32'(a_if.count_o), exp_a[0].count);
        check("a_ovf", 32'(a_if.overflow_o), exp_a[0].ovf);
        if (a_if.result_ready_i) void'(exp_a.pop_front());
      end
    end
  end

  always @(negedge clk_i) begin
    if (reset_n && b_if.result_valid_o) begin
      if (exp_b.size() == 0) begin
        checks++;
        $display("FAIL b_unexpected: got result_valid=1 expected no pending batch");
      end else begin
        check("b_sum", 32'(b_if.sum_o), exp_b[0].sum);
        check("b_max", 32'(b_if.max_o), exp_b[0].max);
        check("b_count", 32'(b_if.count_o), exp_b[0].count);
        check("b_ovf", 32'(b_if.overflow_o), exp_b[0].ovf);
        if (b_if.result_ready_i) void'(exp_b.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ovf_sum;
`ifdef SATURATE_EN
    ovf_sum = 4095;
`else
    ovf_sum = 1004;
`endif
    checks  = 0;
    passed  = 0;
    reset_n = 1'b0;
    a_if.start_i = 1'b0; a_if.in_valid_i = 1'b0; a_if.data_i = '0; a_if.result_ready_i = 1'b0;
    b_if.start_i = 1'b0; b_if.in_valid_i = 1'b0; b_if.data_i = '0; b_if.result_ready_i = 1'b0;

    // 1: reset values, in_valid ignored in IDLE
    #10 reset_n = 1'b1;
    tick();
    check("rst_busy", 32'(a_if.busy_o), 0);
    check("rst_valid", 32'(a_if.result_valid_o), 0);
    check("rst_sum", 32'(a_if.sum_o), 0);
    check("rst_max", 32'(a_if.max_o), 0);
    check("rst_count", 32'(a_if.count_o), 0);
    check("rst_ovf", 32'(a_if.overflow_o), 0);
    check("rst_b_sum", 32'(b_if.sum_o), 0);
    send_a(77);
    send_a(77);
    check("idle_count", 32'(a_if.count_o), 0);
    check("idle_sum", 32'(a_if.sum_o), 0);
    check("idle_busy", 32'(a_if.busy_o), 0);

    // 2: back-to-back samples
    exp_a.push_back('{sum: 62, max: 28, count: 4, ovf: 0});
    start_a();
    check("t2_busy", 32'(a_if.busy_o), 1);
    send_a(8); send_a(15); send_a(11);
    check("t2_pre_valid", 32'(a_if.result_valid_o), 0);
    check("t2_pre_busy", 32'(a_if.busy_o), 1);
    send_a(28);
    check("t2_valid", 32'(a_if.result_valid_o), 1);
    check("t2_busy_drop", 32'(a_if.busy_o), 0);
    tick();
    release_a();
    check("t2_idle_valid", 32'(a_if.result_valid_o), 0);
    check("t2_idle_busy", 32'(a_if.busy_o), 0);
    check("t2_hold_sum", 32'(a_if.sum_o), 62);
    check("t2_hold_count", 32'(a_if.count_o), 4);

    // 3: gapped samples, ready held low for 5 cycles
    exp_a.push_back('{sum: 62, max: 28, count: 4, ovf: 0});
    start_a();
    send_a(8);  tick(); check("t3_busy0", 32'(a_if.busy_o), 1); tick();
    send_a(15); tick(); check("t3_busy1", 32'(a_if.busy_o), 1); tick();
    send_a(11); tick(); check("t3_busy2", 32'(a_if.busy_o), 1); tick();
    check("t3_count3", 32'(a_if.count_o), 3);
    send_a(28);
    check("t3_valid", 32'(a_if.result_valid_o), 1);
    repeat (5) tick();
    check("t3_still_valid", 32'(a_if.result_valid_o), 1);
    release_a();
    check("t3_idle_valid", 32'(a_if.result_valid_o), 0);

    // 4: overflow on the 20-sample instance
    exp_b.push_back('{sum: ovf_sum, max: 255, count: 20, ovf: 1});
    b_if.start_i = 1'b1;
    tick();
    b_if.start_i    = 1'b0;
    b_if.in_valid_i = 1'b1;
    b_if.data_i     = 8'd255;
    repeat (20) tick();
    b_if.in_valid_i = 1'b0;
    check("t4_valid", 32'(b_if.result_valid_o), 1);
    check("t4_ovf", 32'(b_if.overflow_o), 1);
    b_if.result_ready_i = 1'b1;
    tick();
    b_if.result_ready_i = 1'b0;
    check("t4_idle_valid", 32'(b_if.result_valid_o), 0);
    check("t4_ovf_sticky", 32'(b_if.overflow_o), 1);

    // 5: asynchronous reset mid-batch, then a clean batch
    start_a();
    send_a(100);
    send_a(200);
    reset_n = 1'b0;
    #1;
    check("t5_sum", 32'(a_if.sum_o), 0);
    check("t5_max", 32'(a_if.max_o), 0);
    check("t5_count", 32'(a_if.count_o), 0);
    check("t5_busy", 32'(a_if.busy_o), 0);
    #2 reset_n = 1'b1;
    tick();
    exp_a.push_back('{sum: 10, max: 4, count: 4, ovf: 0});
    start_a();
    send_a(1); send_a(2); send_a(3); send_a(4);
    release_a();

    // 6: start ignored in ACCUM/DONE; repeated equal maxima; zero samples count
    exp_a.push_back('{sum: 30, max: 9, count: 4, ovf: 0});
    start_a();
    send_a(9);
    a_if.start_i = 1'b1;
    send_a(9);
    a_if.start_i = 1'b0;
    check("t6_count", 32'(a_if.count_o), 2);
    check("t6_sum", 32'(a_if.sum_o), 18);
    send_a(3);
    send_a(9);
    a_if.start_i = 1'b1;
    tick();
    check("t6_done_start", 32'(a_if.result_valid_o), 1);
    a_if.result_ready_i = 1'b1;
    tick();
    a_if.start_i        = 1'b0;
    a_if.result_ready_i = 1'b0;
    check("t6_idle_valid", 32'(a_if.result_valid_o), 0);
    tick();
    check("t6_no_restart", 32'(a_if.busy_o), 0);
    check("t6_hold_sum", 32'(a_if.sum_o), 30);
    exp_a.push_back('{sum: 0, max: 0, count: 4, ovf: 0});
    start_a();
    send_a(0); send_a(0); send_a(0); send_a(0);
    check("t6_zero_valid", 32'(a_if.result_valid_o), 1);
    release_a();

    repeat (20) tick();
    check("a_queue_drained", 32'(exp_a.size()), 0);
    check("b_queue_drained", 32'(exp_b.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
